multiword_add_seq: RTL and testbench



---
 rtl/multiword_add_seq_pkg.sv | 15 +
 rtl/multiword_add_seq_add_chunk.sv | 38 +++
 rtl/multiword_add_seq.sv | 155 +++++++++++++++
 tb/tb_multiword_add_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared types and default sizing for the iterative multi-precision adder.
package multiword_add_seq_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned WORDS_DEF = 4;
    localparam int unsigned W         = N_DEF * WORDS_DEF;
    localparam int unsigned IDX_W     = $clog2(WORDS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multiword_add_seq_add_chunk.sv
// N-bit carry-select adder: rippled lower half, upper half precomputed for both carries.
module add_chunk #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned LO_W = N / 2;
    localparam int unsigned HI_W = N - LO_W;

    logic [LO_W:0] lo_c;
    logic [HI_W:0] hi0_c;
    logic [HI_W:0] hi1_c;

    // Lower half ripples from cin; both upper-half candidates are formed in parallel.
    always_comb begin
        lo_c  = (LO_W+1)'(a[LO_W-1:0]) + (LO_W+1)'(b[LO_W-1:0]) + (LO_W+1)'(cin);
        hi0_c = (HI_W+1)'(a[N-1:LO_W]) + (HI_W+1)'(b[N-1:LO_W]);
        hi1_c = (HI_W+1)'(a[N-1:LO_W]) + (HI_W+1)'(b[N-1:LO_W]) + (HI_W+1)'(1'b1);
    end

    // Lower-half carry picks the upper-half candidate.
    always_comb begin
        sum[LO_W-1:0] = lo_c[LO_W-1:0];
        if (lo_c[LO_W]) begin
            sum[N-1:LO_W] = hi1_c[HI_W-1:0];
            cout          = hi1_c[HI_W];
        end else begin
            sum[N-1:LO_W] = hi0_c[HI_W-1:0];
            cout          = hi0_c[HI_W];
        end
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Iterative W-bit add/subtract: one N-bit chunk per cycle, LS chunk first, carry registered.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned WORDS = WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int unsigned OP_W = N * WORDS;
    localparam int unsigned IX_W = $clog2(WORDS);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   opa_q, opa_d;
    logic [OP_W-1:0]   opb_q, opb_d;
    logic [OP_W-1:0]   sum_q, sum_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [N-1:0]      opa_chunk_c;
    logic [N-1:0]      opb_chunk_c;
    logic [N-1:0]      chunk_sum_c;
    logic              chunk_cout_c;
    logic              last_c;

    assign last_c = (idx_q == IX_W'(WORDS - 1));

    // Select the operand chunks addressed by the current index.
    always_comb begin
        opa_chunk_c = '0;
        opb_chunk_c = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IX_W'(w)) begin
                opa_chunk_c = opa_q[w*N +: N];
                opb_chunk_c = opb_q[w*N +: N];
            end
        end
    end

    add_chunk #(.N(N)) u_add_chunk (
        .a    (opa_chunk_c),
        .b    (opb_chunk_c),
        .cin  (carry_q),
        .sum  (chunk_sum_c),
        .cout (chunk_cout_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered so busy/done align with the state they describe.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Datapath next-state: latch operands on accept, fold in one chunk per RUN cycle.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IX_W'(w)) sum_d[w*N +: N] = chunk_sum_c;
                end
                carry_d = chunk_cout_c;
                if (last_c) begin
                    cout_d = chunk_cout_c;
                    ovf_d  = (opa_q[OP_W-1] == opb_q[OP_W-1]) &&
                             (chunk_sum_c[N-1] != opa_q[OP_W-1]);
                end else begin
                    idx_d = idx_q + IX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=8, WORDS=4).
module tb_multiword_add_seq;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned OW    = N * WORDS;

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          sub;
        logic [OW-1:0] exp_sum;
        logic          exp_cout;
        logic          exp_ovf;
        bit            inject;
    } vec_t;

    typedef struct {
        logic [OW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic          busy;
    logic          done;
    logic [OW-1:0] sum;
    logic          cout;
    logic          ovf;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[7];

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-width add of A and (sub ? ~B : B) with carry-in = sub.
    function automatic exp_t model(input logic [OW-1:0] xa, input logic [OW-1:0] xb, input logic xs);
        exp_t          r;
        logic [OW-1:0] ob;
        logic [OW:0]   t;
        ob     = xs ? ~xb : xb;
        t      = {1'b0, xa} + {1'b0, ob} + {{OW{1'b0}}, xs};
        r.sum  = t[OW-1:0];
        r.cout = t[OW];
        r.ovf  = (xa[OW-1] == ob[OW-1]) && (t[OW-1] != xa[OW-1]);
        return r;
    endfunction

    // Issue one operation, watch a fixed window, compare at done via the scoreboard.
    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t got;
        int   done_cnt;
        int   done_at;
        int   busy_cnt;
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        start = 1'b1;
        e.sum  = v.exp_sum;
        e.cout = v.exp_cout;
        e.ovf  = v.exp_ovf;
        sb.push_back(e);
        @(posedge clk);
        done_cnt = 0;
        done_at  = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: done with no pending op, sum=%h", sum);
                end else begin
                    got = sb.pop_front();
                    check("sum", 64'(sum), 64'(got.sum));
                    check("cout", 64'(cout), 64'(got.cout));
                    check("ovf", 64'(ovf), 64'(got.ovf));
                end
            end
            start = 1'b0;
            if (k == 1) begin
                a = ~v.a;
                b = ~v.b;
            end
            if (v.inject && k == 2) begin
                start = 1'b1;
                a     = '1;
                b     = '1;
                sub   = ~v.sub;
            end
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_latency", 64'(done_at), 64'(WORDS + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(WORDS + 1));
        check("sum_hold", 64'(sum), 64'(v.exp_sum));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        sub      = 1'b0;
        a        = '1;
        b        = '1;

        //           a             b             sub   sum           cout  ovf   inject
        vecs[0] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0};

        // Reset held for two edges with start asserted.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Reset mid-operation: drop rst_n for the second RUN edge.
        begin
            int   spurious;
            @(negedge clk);
            a     = 32'hFFFFFFFF;
            b     = 32'h00000001;
            sub   = 1'b0;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_done", 64'(done), 64'd0);
            check("midrst_sum", 64'(sum), 64'd0);
            spurious = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done || busy) spurious++;
            end
            check("midrst_no_done", 64'(spurious), 64'd0);
        end
        run_op(vecs[6]);

        // Randomised operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            exp_t m;
            v.a      = $urandom;
            v.b      = $urandom;
            v.sub    = 1'($urandom_range(0, 1));
            m        = model(v.a, v.b, v.sub);
            v.exp_sum  = m.sum;
            v.exp_cout = m.cout;
            v.exp_ovf  = m.ovf;
            v.inject   = (i == 3);
            run_op(v);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
